// File: rtl/dac_serializer.sv
// ---------------------------------------------------------------------------
// dac_serializer
//
// Purpose:
//   Takes the 8-bit attenuated wave sample and writes it to an external
//   MCP4901-class SPI DAC. A free-running sample counter produces the
//   sample-rate tick. Each accepted tick latches one 16-bit write word
//   {CFG, wave, 4'b0000}. The word is shifted out MSB first and then
//   committed with an LDAC strobe.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   enable      in   when low, ticks do not start new frames
//   wave[7:0]   in   unsigned sample, captured only on an accepted tick
//   dac_cs_n    out  DAC chip select, active low
//   dac_sck     out  DAC serial clock, idles low
//   dac_sdi     out  DAC serial data, MSB first
//   dac_ldac_n  out  DAC output latch strobe, active low
//   busy        out  high while a frame (SETUP..LDAC) is in progress
//   sample_tick out  one-cycle pulse at every sample-counter wrap
//   overrun     out  one-cycle pulse when a tick is dropped because busy
//
// Every output is driven directly by a flop.
// ---------------------------------------------------------------------------
module dac_serializer #(
  parameter int         CLK_DIV    = 4,
  parameter int         SAMPLE_DIV = 1000,
  parameter logic [3:0] CFG        = 4'b0011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] wave,
  output logic       dac_cs_n,
  output logic       dac_sck,
  output logic       dac_sdi,
  output logic       dac_ldac_n,
  output logic       busy,
  output logic       sample_tick,
  output logic       overrun
);

  // Counter widths. A width of at least 1 is kept when CLK_DIV is 1.
  localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [SW-1:0] S_LAST  = SW'(SAMPLE_DIV - 1);
  localparam logic [HW-1:0] HP_LAST = HW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_CSHI,
    S_LDAC
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   samp_cnt_q, samp_cnt_d;
  logic [HW-1:0]   hp_cnt_q, hp_cnt_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;     // counts sck falls, 0..16
  logic [15:0]     shift_q, shift_d;
  logic            go_q, go_d;               // accepted tick: start a frame
  logic            tick_q, tick_d;
  logic            overrun_q, overrun_d;
  logic            cs_n_q, cs_n_d;
  logic            sck_q, sck_d;
  logic            sdi_q, sdi_d;
  logic            ldac_n_q, ldac_n_d;
  logic            busy_q, busy_d;
  logic            hp_last;
  logic            frame_active_d;

  assign hp_last = (hp_cnt_q == HP_LAST);

  always_comb begin
    // Sample counter free-runs regardless of enable or the frame state.
    samp_cnt_d = (samp_cnt_q == S_LAST) ? '0 : samp_cnt_q + 1'b1;
    // Computed from the next count so that tick_q is high exactly while
    // the counter sits at SAMPLE_DIV-1.
    tick_d     = (samp_cnt_d == S_LAST);

    state_d   = state_q;
    hp_cnt_d  = hp_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sck_d     = sck_q;

    case (state_q)
      S_IDLE: begin
        sck_d     = 1'b0;
        hp_cnt_d  = '0;
        bit_cnt_d = '0;
        // go_q coincides with the tick cycle, so wave is captured here.
        if (go_q) begin
          shift_d = {CFG, wave, 4'b0000};
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (hp_last) begin
          hp_cnt_d = '0;
          sck_d    = 1'b1;               // first rise opens SHIFT
          state_d  = S_SHIFT;
        end else begin
          hp_cnt_d = hp_cnt_q + 1'b1;
        end
      end

      S_SHIFT: begin
        if (hp_last) begin
          hp_cnt_d = '0;
          if (sck_q) begin
            // Falling edge: advance data so it is settled a full half
            // period before the next rise.
            sck_d     = 1'b0;
            shift_d   = {shift_q[14:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (bit_cnt_q == 5'd16) begin
            // Low half period after the 16th fall has completed.
            bit_cnt_d = '0;
            state_d   = S_CSHI;
          end else begin
            sck_d = 1'b1;
          end
        end else begin
          hp_cnt_d = hp_cnt_q + 1'b1;
        end
      end

      S_CSHI: begin
        if (hp_last) begin
          hp_cnt_d = '0;
          state_d  = S_LDAC;
        end else begin
          hp_cnt_d = hp_cnt_q + 1'b1;
        end
      end

      S_LDAC: begin
        if (hp_last) begin
          hp_cnt_d = '0;
          state_d  = S_IDLE;
        end else begin
          hp_cnt_d = hp_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d  = S_IDLE;
        hp_cnt_d = '0;
        sck_d    = 1'b0;
      end
    endcase

    // The accept/drop decision uses the state the tick cycle will have.
    // This keeps go_q and overrun_q aligned with tick_q.
    go_d      = tick_d && enable && (state_d == S_IDLE);
    overrun_d = tick_d && enable && (state_d != S_IDLE);

    // Pin values are derived from the next state, so they change on the
    // same edge as the state itself.
    frame_active_d = (state_d == S_SETUP) || (state_d == S_SHIFT);
    cs_n_d         = !frame_active_d;
    sdi_d          = frame_active_d ? shift_d[15] : 1'b0;
    ldac_n_d       = (state_d != S_LDAC);
    busy_d         = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      samp_cnt_q <= '0;
      hp_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      go_q       <= 1'b0;
      tick_q     <= 1'b0;
      overrun_q  <= 1'b0;
      cs_n_q     <= 1'b1;
      sck_q      <= 1'b0;
      sdi_q      <= 1'b0;
      ldac_n_q   <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      hp_cnt_q   <= hp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      go_q       <= go_d;
      tick_q     <= tick_d;
      overrun_q  <= overrun_d;
      cs_n_q     <= cs_n_d;
      sck_q      <= sck_d;
      sdi_q      <= sdi_d;
      ldac_n_q   <= ldac_n_d;
      busy_q     <= busy_d;
    end
  end

  assign dac_cs_n    = cs_n_q;
  assign dac_sck     = sck_q;
  assign dac_sdi     = sdi_q;
  assign dac_ldac_n  = ldac_n_q;
  assign busy        = busy_q;
  assign sample_tick = tick_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_dac_serializer.sv
// ---------------------------------------------------------------------------
// tb_dac_serializer
//
// This bench runs three instances of dac_serializer, all with CLK_DIV=2:
//   0: SAMPLE_DIV=80, CFG=0011  (basic, isolation, gating, async reset)
//   1: SAMPLE_DIV=40, CFG=0011  (overrun every second tick)
//   2: SAMPLE_DIV=80, CFG=0111  (boundary data words)
// The instances share clk, reset, enable and wave. Only the instance chosen
// by sel is observed. DUT outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_dac_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] wave = 8'h00;
  logic [1:0] sel = 2'd0;

  logic [2:0] cs_n_w, sck_w, sdi_w, ldac_w, busy_w, tick_w, ovr_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int         SD  = (gi == 1) ? 40 : 80;
    localparam logic [3:0] CF  = (gi == 2) ? 4'b0111 : 4'b0011;
    dac_serializer #(
      .CLK_DIV   (2),
      .SAMPLE_DIV(SD),
      .CFG       (CF)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .wave       (wave),
      .dac_cs_n   (cs_n_w[gi]),
      .dac_sck    (sck_w[gi]),
      .dac_sdi    (sdi_w[gi]),
      .dac_ldac_n (ldac_w[gi]),
      .busy       (busy_w[gi]),
      .sample_tick(tick_w[gi]),
      .overrun    (ovr_w[gi])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] pins();
    return {cs_n_w[sel], sck_w[sel], sdi_w[sel], ldac_w[sel],
            busy_w[sel], tick_w[sel], ovr_w[sel]};
  endfunction

  // Reset pattern: cs_n=1 sck=0 sdi=0 ldac_n=1 busy=0 tick=0 overrun=0
  localparam logic [6:0] RST_PINS = 7'b1001000;

  task automatic do_reset(input string tag);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq(tag, {25'd0, pins()}, {25'd0, RST_PINS});
    reset = 1'b0;
  endtask

  // Wait for the first tick after reset release. Cycle 1 is the cycle in
  // which the sample counter holds 0. Must be called at the release negedge.
  task automatic first_tick_cycle(output int cyc);
    int c;
    c = 1;
    while (!tick_w[sel] && c < 500) begin
      @(negedge clk);
      c++;
    end
    cyc = c;
  endtask

  // Observe one frame on the selected instance. Optionally applies an action
  // act_at cycles into the frame: cycle 0 is the first busy cycle.
  // kind 1 drives wave=act_val, kind 2 drops enable.
  task automatic measure_frame(input int act_at, input int kind,
                               input logic [7:0] act_val,
                               output int cs_low, output int rises,
                               output int ldac_low, output int busy_cnt,
                               output logic [15:0] word, output int tick_lead,
                               output int cs_edges, output int ovr);
    int   n;
    logic prev_tick, prev_sck, prev_cs;
    cs_low = 0; rises = 0; ldac_low = 0; busy_cnt = 0; word = '0;
    cs_edges = 0; ovr = 0;
    prev_tick = tick_w[sel];
    n = 0;
    @(negedge clk);
    while (!busy_w[sel] && n < 400) begin
      prev_tick = tick_w[sel];
      @(negedge clk);
      n++;
    end
    tick_lead = {31'd0, prev_tick};
    check_eq("frame_start", {31'd0, busy_w[sel]}, 32'd1);
    prev_sck = 1'b0;
    prev_cs  = 1'b1;
    n = 0;
    while (busy_w[sel] && n < 400) begin
      if (!cs_n_w[sel]) cs_low++;
      if (!ldac_w[sel]) ldac_low++;
      busy_cnt++;
      if (sck_w[sel] && !prev_sck) begin
        rises++;
        word = {word[14:0], sdi_w[sel]};
      end
      if (cs_n_w[sel] != prev_cs) cs_edges++;
      if (ovr_w[sel]) ovr++;
      prev_sck = sck_w[sel];
      prev_cs  = cs_n_w[sel];
      if (n == act_at) begin
        if (kind == 1) wave = act_val;
        if (kind == 2) enable = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    $display("frame inst=%0d word=0x%04h cs_low=%0d rises=%0d ldac_low=%0d busy=%0d",
             sel, word, cs_low, rises, ldac_low, busy_cnt);
  endtask

  initial begin
    int          cs_low, rises, ldac_low, busy_cnt, tick_lead, cs_edges, ovr;
    logic [15:0] word;
    int          c, ticks, t_first, t_second, cnt_cs, cnt_ovr, cnt_busy;
    logic [7:0]  mask;
    int          nstart, s0, s1, s2, s3, ovr_idle, cs_falls, sck_rises, ovr_tot;
    logic        prev_busy, prev_cs, prev_sck;

    // ---------------- reset values, tick timing, enable gating ------------
    sel = 2'd0; enable = 1'b0; wave = 8'h00;
    do_reset("reset_pins_a");
    c = 1; ticks = 0; t_first = 0; t_second = 0;
    cnt_cs = 0; cnt_ovr = 0; cnt_busy = 0;
    while (ticks < 3 && c < 400) begin
      @(negedge clk);
      c++;
      if (tick_w[0]) begin
        ticks++;
        if (ticks == 1) t_first = c;
        if (ticks == 2) t_second = c;
      end
      if (!cs_n_w[0]) cnt_cs++;
      if (ovr_w[0]) cnt_ovr++;
      if (busy_w[0]) cnt_busy++;
    end
    $display("gating ticks=%0d first=%0d spacing=%0d", ticks, t_first, t_second - t_first);
    check_eq("gate_ticks", ticks, 3);
    check_eq("first_tick_cycle", t_first, 80);
    check_eq("tick_spacing", t_second - t_first, 80);
    check_eq("gate_cs_low", cnt_cs, 0);
    check_eq("gate_overrun", cnt_ovr, 0);
    check_eq("gate_busy", cnt_busy, 0);

    // ---------------- basic frame -----------------------------------------
    enable = 1'b1; wave = 8'hA5;
    measure_frame(-1, 0, 8'h00, cs_low, rises, ldac_low, busy_cnt, word,
                  tick_lead, cs_edges, ovr);
    check_eq("basic_word", {16'd0, word}, 32'h3A50);
    check_eq("basic_cs_low", cs_low, 66);
    check_eq("basic_rises", rises, 16);
    check_eq("basic_ldac_low", ldac_low, 2);
    check_eq("basic_busy", busy_cnt, 70);
    check_eq("basic_busy_after_tick", tick_lead, 1);
    check_eq("basic_cs_edges", cs_edges, 2);
    check_eq("basic_overrun", ovr, 0);

    // ---------------- sample isolation ------------------------------------
    wave = 8'h00;
    measure_frame(1, 1, 8'hFF, cs_low, rises, ldac_low, busy_cnt, word,
                  tick_lead, cs_edges, ovr);
    check_eq("iso_word_old", {16'd0, word}, 32'h3000);
    measure_frame(-1, 0, 8'h00, cs_low, rises, ldac_low, busy_cnt, word,
                  tick_lead, cs_edges, ovr);
    check_eq("iso_word_new", {16'd0, word}, 32'h3FF0);

    // ---------------- enable dropped mid-frame ----------------------------
    wave = 8'h3C;
    measure_frame(20, 2, 8'h00, cs_low, rises, ldac_low, busy_cnt, word,
                  tick_lead, cs_edges, ovr);
    check_eq("en_drop_word", {16'd0, word}, 32'h33C0);
    check_eq("en_drop_busy", busy_cnt, 70);
    check_eq("en_drop_cs_low", cs_low, 66);
    cnt_busy = 0; cnt_ovr = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy_w[0]) cnt_busy++;
      if (ovr_w[0]) cnt_ovr++;
    end
    check_eq("en_off_no_frame", cnt_busy, 0);
    check_eq("en_off_no_overrun", cnt_ovr, 0);

    // ---------------- async reset in SHIFT --------------------------------
    enable = 1'b1; wave = 8'h5A;
    c = 0;
    while (!busy_w[0] && c < 200) begin
      @(negedge clk);
      c++;
    end
    check_eq("rst_frame_start", {31'd0, busy_w[0]}, 32'd1);
    rises = 0; prev_sck = 1'b0; c = 0;
    while (rises < 5 && c < 200) begin
      if (sck_w[0] && !prev_sck) rises++;
      prev_sck = sck_w[0];
      if (rises < 5) @(negedge clk);
      c++;
    end
    check_eq("rst_pre_rises", rises, 5);
    // Assert reset while clk is low, then look before the next rising edge.
    #2 reset = 1'b1;
    #1 check_eq("async_reset_pins", {25'd0, pins()}, {25'd0, RST_PINS});
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    first_tick_cycle(t_first);
    $display("post-reset first tick cycle=%0d", t_first);
    check_eq("rst_first_tick", t_first, 80);
    measure_frame(-1, 0, 8'h00, cs_low, rises, ldac_low, busy_cnt, word,
                  tick_lead, cs_edges, ovr);
    check_eq("rst_word", {16'd0, word}, 32'h35A0);
    check_eq("rst_busy", busy_cnt, 70);
    check_eq("rst_rises", rises, 16);
    check_eq("rst_busy_after_tick", tick_lead, 1);

    // ---------------- overrun (SAMPLE_DIV=40) -----------------------------
    sel = 2'd1; enable = 1'b1; wave = 8'h11;
    do_reset("reset_pins_b");
    c = 1; ticks = 0; mask = '0; nstart = 0; s0 = 0; s1 = 0; s2 = 0; s3 = 0;
    ovr_idle = 0; cs_falls = 0; sck_rises = 0; ovr_tot = 0;
    prev_busy = 1'b0; prev_cs = 1'b1; prev_sck = 1'b0;
    while (c < 350) begin
      @(negedge clk);
      c++;
      if (tick_w[1]) begin
        if (ticks < 8) mask = {ovr_w[1], mask[7:1]};
        ticks++;
      end
      if (ovr_w[1]) ovr_tot++;
      if (ovr_w[1] && !busy_w[1]) ovr_idle++;
      if (busy_w[1] && !prev_busy) begin
        case (nstart)
          0: s0 = c;
          1: s1 = c;
          2: s2 = c;
          3: s3 = c;
          default: ;
        endcase
        nstart++;
      end
      if (!cs_n_w[1] && prev_cs) cs_falls++;
      if (sck_w[1] && !prev_sck) sck_rises++;
      prev_busy = busy_w[1];
      prev_cs   = cs_n_w[1];
      prev_sck  = sck_w[1];
    end
    $display("overrun ticks=%0d mask=0x%02h starts=%0d,%0d,%0d,%0d", ticks, mask, s0, s1, s2, s3);
    check_eq("ovr_ticks", ticks, 8);
    check_eq("ovr_mask", {24'd0, mask}, 32'h0000_00AA);
    check_eq("ovr_total", ovr_tot, 4);
    check_eq("ovr_frames", nstart, 4);
    check_eq("ovr_first_start", s0, 41);
    check_eq("ovr_spacing_01", s1 - s0, 80);
    check_eq("ovr_spacing_23", s3 - s2, 80);
    check_eq("ovr_cs_falls", cs_falls, 4);
    check_eq("ovr_sck_rises", sck_rises, 64);
    check_eq("ovr_while_idle", ovr_idle, 0);

    // ---------------- boundary words, CFG=0111 ----------------------------
    sel = 2'd2; enable = 1'b1; wave = 8'h00;
    do_reset("reset_pins_c");
    measure_frame(-1, 0, 8'h00, cs_low, rises, ldac_low, busy_cnt, word,
                  tick_lead, cs_edges, ovr);
    check_eq("bnd_word_00", {16'd0, word}, 32'h7000);
    wave = 8'hFF;
    measure_frame(-1, 0, 8'h00, cs_low, rises, ldac_low, busy_cnt, word,
                  tick_lead, cs_edges, ovr);
    check_eq("bnd_word_ff", {16'd0, word}, 32'h7FF0);
    check_eq("bnd_busy", busy_cnt, 70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
